// File: rtl/multicycle_ctrl_seq.sv
// Multi-cycle LOAD/STORE/ADD control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// req/ack fetch, memory-ready wait with timeout, retire counter and error trapping.
module multicycle_ctrl_seq #(
  parameter int IW          = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             err_clr,
  output logic             instr_req,
  input  logic             instr_ack,
  input  logic [IW-1:0]    instr_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic             mem_ready,
  output logic             alu_op,
  output logic             reg_write_enable,
  output logic             pc_inc,
  output logic             busy,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       state_o
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t          state, state_next;
  logic [3:0]      opcode, opcode_next;
  logic [TW-1:0]   timer, timer_next;
  logic            retire;
  logic            set_ill;
  logic            set_tmo;
  logic            clr_flags;
  logic            unused_bits;

  // Only the opcode nibble of the instruction word matters to the sequencer.
  assign unused_bits = ^instr_data[IW-5:0];
  assign state_o     = state;

  // Next-state, opcode latch, MEM timer and retire/flag events.
  always_comb begin
    state_next  = state;
    opcode_next = opcode;
    timer_next  = timer;
    retire      = 1'b0;
    set_ill     = 1'b0;
    set_tmo     = 1'b0;
    clr_flags   = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
        else     state_next = IDLE;
      end
      FETCH: begin
        if (instr_ack) begin
          opcode_next = instr_data[IW-1 -: 4];
          state_next  = DECODE;
        end else begin
          state_next  = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: begin
            state_next = MEM;
            timer_next = '0;
          end
          OP_ADD:  state_next = EXEC;
          default: begin
            state_next = ERR;
            set_ill    = 1'b1;
          end
        endcase
      end
      EXEC: state_next = WB;
      MEM: begin
        // Ready takes priority over an expiring timer in the same cycle.
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            retire     = 1'b1;
            state_next = run ? FETCH : IDLE;
          end else begin
            state_next = WB;
          end
        end else if (timer == TMO_LAST) begin
          state_next = ERR;
          set_tmo    = 1'b1;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      WB: begin
        retire     = 1'b1;
        state_next = run ? FETCH : IDLE;
      end
      ERR: begin
        if (err_clr) begin
          state_next = IDLE;
          clr_flags  = 1'b1;
        end else begin
          state_next = ERR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, opcode, timer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      opcode      <= 4'd0;
      timer       <= '0;
      retired_cnt <= '0;
    end else begin
      state       <= state_next;
      opcode      <= opcode_next;
      timer       <= timer_next;
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state, so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_req        <= 1'b0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      alu_op           <= 1'b0;
      reg_write_enable <= 1'b0;
      pc_inc           <= 1'b0;
      busy             <= 1'b0;
      illegal_op       <= 1'b0;
      mem_timeout      <= 1'b0;
    end else begin
      instr_req        <= (state_next == FETCH);
      mem_read         <= (state_next == MEM) && (opcode_next == OP_LOAD);
      mem_write        <= (state_next == MEM) && (opcode_next == OP_STORE);
      alu_op           <= (state_next == EXEC);
      reg_write_enable <= (state_next == WB);
      pc_inc           <= (state_next == DECODE);
      busy             <= (state_next != IDLE);
      if (set_ill)        illegal_op <= 1'b1;
      else if (clr_flags) illegal_op <= 1'b0;
      if (set_tmo)        mem_timeout <= 1'b1;
      else if (clr_flags) mem_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Bench for multicycle_ctrl_seq: directed and random instruction streams checked
// cycle by cycle against an expected trace built from per-instruction rules.
module tb_multicycle_ctrl_seq;

  localparam int MEM_TIMEOUT = 15;
  localparam logic [8:0] F_REQ  = 9'h100;
  localparam logic [8:0] F_RD   = 9'h080;
  localparam logic [8:0] F_WR   = 9'h040;
  localparam logic [8:0] F_ALU  = 9'h020;
  localparam logic [8:0] F_RWE  = 9'h010;
  localparam logic [8:0] F_PC   = 9'h008;
  localparam logic [8:0] F_BUSY = 9'h004;
  localparam logic [8:0] F_ILL  = 9'h002;
  localparam logic [8:0] F_TMO  = 9'h001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       err_clr;
  logic       instr_req;
  logic       instr_ack;
  logic [7:0] instr_data;
  logic       mem_read;
  logic       mem_write;
  logic       mem_ready;
  logic       alu_op;
  logic       reg_write_enable;
  logic       pc_inc;
  logic       busy;
  logic       illegal_op;
  logic       mem_timeout;
  logic [7:0] retired_cnt;
  logic [2:0] state_o;

  int         total = 0;
  int         bad = 0;
  logic [7:0] model_cnt = 8'd0;
  int         retire_total = 0;
  bit         in_fetch;

  multicycle_ctrl_seq #(.IW(8), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .err_clr(err_clr),
    .instr_req(instr_req), .instr_ack(instr_ack), .instr_data(instr_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .alu_op(alu_op), .reg_write_enable(reg_write_enable), .pc_inc(pc_inc),
    .busy(busy), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .retired_cnt(retired_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected state code, strobe set and retire count.
  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [8:0] flags);
    logic [11:0] got;
    got = {state_o, instr_req, mem_read, mem_write, alu_op, reg_write_enable,
           pc_inc, busy, illegal_op, mem_timeout};
    check_eq(tag, {20'd0, got}, {20'd0, st, flags});
    check_eq({tag, "_cnt"}, {24'd0, retired_cnt}, {24'd0, model_cnt});
  endtask

  task automatic note_retire();
    model_cnt = model_cnt + 8'd1;
    retire_total++;
  endtask

  task automatic err_exit(input logic [8:0] flag);
    int hold;
    hold = $urandom_range(0, 2);
    expect_cyc("err", 3'd6, F_BUSY | flag);
    for (int h = 0; h < hold; h++) begin
      step();
      expect_cyc("err_hold", 3'd6, F_BUSY | flag);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    expect_cyc("err_clr", 3'd0, 9'h000);
  endtask

  task automatic idle_restart();
    expect_cyc("idle", 3'd0, 9'h000);
    run = 1'b0;
    step();
    expect_cyc("idle_hold", 3'd0, 9'h000);
    run = 1'b1;
    step();
  endtask

  // One instruction from its first FETCH cycle to retire or error recovery.
  task automatic do_instr(input logic [3:0] op, input int ack_wait, input int rdy_wait,
                          input bit keep, output bit fetch_next);
    bit done;
    int k;
    run = 1'b1;
    for (int i = 0; i <= ack_wait; i++) begin
      expect_cyc("fetch", 3'd1, F_REQ | F_BUSY);
      instr_ack  = (i == ack_wait);
      instr_data = {op, 4'($urandom)};
      step();
    end
    instr_ack  = 1'b0;
    instr_data = 8'($urandom);
    expect_cyc("decode", 3'd2, F_PC | F_BUSY);
    run = keep;
    step();
    fetch_next = 1'b0;
    if (op == 4'd2) begin
      expect_cyc("exec", 3'd3, F_ALU | F_BUSY);
      step();
      expect_cyc("wb_add", 3'd5, F_RWE | F_BUSY);
      step();
      note_retire();
      fetch_next = keep;
    end else if (op == 4'd0 || op == 4'd1) begin
      done = 1'b0;
      k = 0;
      while (!done) begin
        expect_cyc(op == 4'd0 ? "mem_rd" : "mem_wr", 3'd4, (op == 4'd0 ? F_RD : F_WR) | F_BUSY);
        mem_ready = (k == rdy_wait);
        step();
        mem_ready = 1'b0;
        if (k == rdy_wait) begin
          done = 1'b1;
          if (op == 4'd0) begin
            expect_cyc("wb_load", 3'd5, F_RWE | F_BUSY);
            step();
          end
          note_retire();
          fetch_next = keep;
        end else if (k == MEM_TIMEOUT - 1) begin
          done = 1'b1;
          err_exit(F_TMO);
        end
        k++;
      end
    end else begin
      err_exit(F_ILL);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    int         sel;
    int         guard;
    rst_n = 1'b0; run = 1'b0; err_clr = 1'b0;
    instr_ack = 1'b0; instr_data = 8'h00; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_cyc("reset", 3'd0, 9'h000);
    @(negedge clk) rst_n = 1'b1;
    step();
    expect_cyc("idle_after_reset", 3'd0, 9'h000);

    // Asynchronous reset while a LOAD waits in MEM.
    run = 1'b1;
    step();
    expect_cyc("fetch", 3'd1, F_REQ | F_BUSY);
    instr_ack = 1'b1; instr_data = 8'h00;
    step();
    instr_ack = 1'b0;
    expect_cyc("decode", 3'd2, F_PC | F_BUSY);
    step();
    expect_cyc("mem_rd", 3'd4, F_RD | F_BUSY);
    step();
    expect_cyc("mem_rd", 3'd4, F_RD | F_BUSY);
    #2 rst_n = 1'b0;
    #1 expect_cyc("async_reset", 3'd0, 9'h000);
    run = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    idle_restart();
    do_instr(4'd2, 0, 0, 1'b0, in_fetch);
    check_eq("add_retired", {24'd0, retired_cnt}, 32'd1);
    idle_restart();
    do_instr(4'd0, 1, 3, 1'b1, in_fetch);
    do_instr(4'd1, 0, 2, 1'b0, in_fetch);
    idle_restart();
    do_instr(4'hF, 0, 0, 1'b1, in_fetch);
    idle_restart();
    do_instr(4'd0, 0, 99, 1'b1, in_fetch);
    idle_restart();
    do_instr(4'd0, 0, MEM_TIMEOUT - 1, 1'b0, in_fetch);
    idle_restart();
    do_instr(4'd2, 2, 0, 1'b0, in_fetch);
    expect_cyc("idle_after_run_drop", 3'd0, 9'h000);
    step();
    expect_cyc("no_new_fetch", 3'd0, 9'h000);

    in_fetch = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!in_fetch) idle_restart();
      sel = $urandom_range(0, 11);
      if (sel < 4)       op = 4'd0;
      else if (sel < 7)  op = 4'd1;
      else if (sel < 11) op = 4'd2;
      else               op = 4'($urandom_range(3, 15));
      do_instr(op, $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 5),
               $urandom_range(0, 3) != 0, in_fetch);
    end

    // Keep retiring ADDs until the counter has wrapped through zero.
    guard = 0;
    while (!(retire_total >= 256 && model_cnt == 8'd0) && guard < 400) begin
      if (!in_fetch) idle_restart();
      do_instr(4'd2, 0, 0, 1'b1, in_fetch);
      guard++;
    end
    check_eq("wrap", {24'd0, retired_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
